// File: rtl/mux21_arbiter_pkg.sv
// Shared definitions for the packet-aware 2:1 mux arbiter: state encodings,
// default data width and a grant-state helper.
package mux21_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } state_t;

  function automatic state_t grant_state(input logic idx);
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mux21_arbiter_mux21_w.sv
// WIDTH+1-bit 2:1 mux carrying a beat's data plus its last flag.
module mux21_w
  import mux21_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           i_sel,
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux21_arbiter.sv
// Two-requester packet-aware round-robin arbiter steering a 2:1 mux into a
// one-entry registered output channel with backpressure.
module mux21_arbiter
  import mux21_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_served;
  logic             w_last_served_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_src;

  logic             w_load_en;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_acc;
  logic             w_gnt_idx;
  logic             w_other_valid;
  logic [WIDTH:0]   w_mux_y;

  mux21_w #(.WIDTH(WIDTH)) u_mux (
    .i_sel (r_sel),
    .i_a   ({req0_last, req0_data}),
    .i_b   ({req1_last, req1_data}),
    .o_y   (w_mux_y)
  );

  // Ready depends only on state and the output slot, never on the valids.
  always_comb begin
    w_load_en     = !r_out_valid || out_ready;
    w_ready0      = !rst && (r_state == ST_GRANT0) && w_load_en;
    w_ready1      = !rst && (r_state == ST_GRANT1) && w_load_en;
    w_acc         = (w_ready0 && req0_valid) || (w_ready1 && req1_valid);
    w_gnt_idx     = (r_state == ST_GRANT1);
    w_other_valid = w_gnt_idx ? req0_valid : req1_valid;
  end

  // Arbitration and packet-boundary state transitions.
  always_comb begin
    w_state_nxt       = r_state;
    w_sel_nxt         = r_sel;
    w_last_served_nxt = r_last_served;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          w_state_nxt = grant_state(!r_last_served);
          w_sel_nxt   = !r_last_served;
        end else if (req0_valid) begin
          w_state_nxt = ST_GRANT0;
          w_sel_nxt   = 1'b0;
        end else if (req1_valid) begin
          w_state_nxt = ST_GRANT1;
          w_sel_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        // The owner's next-cycle valid is not visible yet, so without a
        // waiting peer the grant is released and re-arbitrated from IDLE.
        if (w_acc && w_mux_y[WIDTH]) begin
          w_last_served_nxt = w_gnt_idx;
          if (w_other_valid) begin
            w_state_nxt = grant_state(!w_gnt_idx);
            w_sel_nxt   = !w_gnt_idx;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, select and output register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last_served <= 1'b1;
      r_sel         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= {WIDTH{1'b0}};
      r_out_last    <= 1'b0;
      r_out_src     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_served <= w_last_served_nxt;
      r_sel         <= w_sel_nxt;
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_y[WIDTH-1:0];
        r_out_last  <= w_mux_y[WIDTH];
        r_out_src   <= w_gnt_idx;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign sel        = r_sel;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign out_src    = r_out_src;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed and randomized bench for mux21_arbiter with a cycle reference model
// and per-source ordering scoreboard.
module tb_mux21_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_last, req0_ready;
  logic         req1_valid, req1_last, req1_ready;
  logic [W-1:0] req0_data, req1_data, out_data;
  logic         sel, out_valid, out_last, out_src, out_ready;

  always #5 clk = ~clk;

  mux21_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  // beats are {last, data}; observed output beats are {src, last, data}
  logic [4:0] q0[$], q1[$], gen0[$], gen1[$];
  logic [5:0] got[$];
  logic       en0, en1, o_rdy;

  // reference model: owner -1 means nobody is granted
  int         m_owner, m_ls;
  logic       m_sel, m_ov, m_ol, m_os;
  logic [3:0] m_od;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ls = 1; m_sel = 1'b0; m_ov = 1'b0;
    m_od = 4'h0; m_ol = 1'b0; m_os = 1'b0;
  endtask

  task automatic tick();
    logic er0, er1, le, acc, accl, ov0, ov1;
    logic [3:0] accd;
    int pop, other;
    req0_valid = en0 && (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0][3:0] : 4'h0;
    req0_last  = (q0.size() > 0) ? q0[0][4] : 1'b0;
    req1_valid = en1 && (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0][3:0] : 4'h0;
    req1_last  = (q1.size() > 0) ? q1[0][4] : 1'b0;
    out_ready  = o_rdy;
    @(negedge clk);
    le  = !m_ov || o_rdy;
    er0 = !rst && (m_owner == 0) && le;
    er1 = !rst && (m_owner == 1) && le;
    chk("req0_ready", 32'(req0_ready), 32'(er0));
    chk("req1_ready", 32'(req1_ready), 32'(er1));
    chk("sel",        32'(sel),        32'(m_sel));
    chk("out_valid",  32'(out_valid),  32'(m_ov));
    chk("out_data",   32'(out_data),   32'(m_od));
    chk("out_last",   32'(out_last),   32'(m_ol));
    chk("out_src",    32'(out_src),    32'(m_os));
    if (out_valid && out_ready) got.push_back({out_src, out_last, out_data});
    pop = -1;
    if (rst) begin
      model_reset();
    end else begin
      ov0  = req0_valid;
      ov1  = req1_valid;
      acc  = (er0 && ov0) || (er1 && ov1);
      accd = (m_owner == 1) ? req1_data : req0_data;
      accl = (m_owner == 1) ? req1_last : req0_last;
      if (acc) begin
        pop = m_owner;
        m_ov = 1'b1; m_od = accd; m_ol = accl; m_os = m_owner[0];
      end else if (o_rdy) begin
        m_ov = 1'b0;
      end
      if (m_owner < 0) begin
        if (ov0 && ov1) m_owner = 1 - m_ls;
        else if (ov0)   m_owner = 0;
        else if (ov1)   m_owner = 1;
        if (m_owner >= 0) m_sel = m_owner[0];
      end else if (acc && accl) begin
        m_ls  = m_owner;
        other = 1 - m_owner;
        if ((other == 0) ? ov0 : ov1) begin
          m_owner = other;
          m_sel   = other[0];
        end else begin
          m_owner = -1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop == 0) void'(q0.pop_front());
    else if (pop == 1) void'(q1.pop_front());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    en0 = 1'b0; en1 = 1'b0; o_rdy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  // exp holds n 6-bit beats, first expected beat in the most significant slot
  task automatic chk_got(input string tag, input int n, input logic [47:0] exp);
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp[(n-1-i)*6 +: 6]));
    got.delete();
  endtask

  initial begin
    int budget, k0, k1, len;
    model_reset();
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1; o_rdy = 1'b1;
    q0 = {5'h01, 5'h12, 5'h13};
    q1 = {5'h08, 5'h19, 5'h17};
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 4'h1; req1_data = 4'h8; req0_last = 1'b0; req1_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset with both requesters valid, then fairness order
    ticks(2);
    rst = 1'b0;
    tick();
    chk("grant0_after_rst", 32'(req0_ready), 32'd1);
    ticks(7);
    chk_got("fair", 6, {6'h01, 6'h12, 6'h28, 6'h39, 6'h13, 6'h37});

    // single requester packet
    do_reset();
    q0 = {5'h0A, 5'h0B, 5'h1C};
    en0 = 1'b1;
    ticks(6);
    chk("idle_after_pkt", 32'(req0_ready), 32'd0);
    chk_got("single", 3, {18'h0, 6'h0A, 6'h0B, 6'h1C});

    // backpressure on req1 packet
    do_reset();
    q1 = {5'h05, 5'h06, 5'h17};
    en1 = 1'b1;
    ticks(3);
    o_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", 32'(out_data), 32'h6);
      chk("bp_rdy", 32'(req1_ready), 32'd0);
    end
    o_rdy = 1'b1;
    ticks(3);
    chk_got("bp", 3, {18'h0, 6'h25, 6'h26, 6'h37});

    // valid gap inside a req0 packet while req1 waits
    do_reset();
    q0 = {5'h01, 5'h12};
    q1 = {5'h0E, 5'h1F};
    en0 = 1'b1; en1 = 1'b1;
    ticks(2);
    en0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("gap_sel", 32'(sel), 32'd0);
    end
    en0 = 1'b1;
    ticks(4);
    chk_got("gap", 4, {24'h0, 6'h01, 6'h12, 6'h2E, 6'h3F});

    // reset in the middle of a req0 packet
    do_reset();
    q0 = {5'h01, 5'h02, 5'h13};
    en0 = 1'b1;
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete(); en0 = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    got.delete();
    q1 = {5'h0B, 5'h1C};
    en1 = 1'b1;
    ticks(4);
    chk_got("mid_rst", 2, {36'h0, 6'h2B, 6'h3C});

    // randomized traffic against the reference model and scoreboard
    do_reset();
    gen0.delete(); gen1.delete();
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) gen0.push_back({(b == len - 1) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15))});
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) gen1.push_back({(b == len - 1) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15))});
    end
    q0 = gen0; q1 = gen1;
    budget = 3000;
    while ((q0.size() > 0 || q1.size() > 0 || m_ov) && budget > 0) begin
      en0   = ($urandom_range(0, 3) != 0);
      en1   = ($urandom_range(0, 3) != 0);
      o_rdy = ($urandom_range(0, 3) != 0);
      tick();
      budget--;
    end
    chk("rand_drain", 32'(q0.size() + q1.size()), 32'd0);
    k0 = 0; k1 = 0;
    foreach (got[i]) begin
      if (got[i][5] == 1'b0) begin
        if (k0 < gen0.size()) chk("rand_src0", 32'(got[i][4:0]), 32'(gen0[k0]));
        k0++;
      end else begin
        if (k1 < gen1.size()) chk("rand_src1", 32'(got[i][4:0]), 32'(gen1[k1]));
        k1++;
      end
    end
    chk("rand_cnt0", 32'(k0), 32'(gen0.size()));
    chk("rand_cnt1", 32'(k1), 32'(gen1.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
